// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID -> ID/EX pipeline register.
// Reads register file operands with write-back bypass, decodes controls and
// immediates, and detects load-use hazards. Output payload is registered
// behind a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_instr, in_pc fetched payload
//   rs1, rs2            register file read addresses (combinational)
//   rd1, rd2            register file read data (same cycle)
//   wb_we/wb_rd/wb_data write-back port used for bypass
//   flush               drop stage contents (branch redirect)
//   out_valid/out_ready downstream handshake
//   out_*               registered decoded payload and control bits
// out_alu_imm marks instructions whose second ALU operand is the immediate
// (JALR, LOAD, STORE, OP-IMM).
module decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   input  logic [31:0] rd1,
   input  logic [31:0] rd2,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_rs1_val,
   output logic [31:0] out_rs2_val,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rd,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [2:0]  out_funct3,
   output logic        out_funct7b5,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_branch,
   output logic        out_jal,
   output logic        out_jalr,
   output logic        out_alu_imm,
   output logic        out_lui,
   output logic        out_auipc,
   output logic        out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jal;
      logic jalr;
      logic alu_imm;
      logic lui;
      logic auipc;
      logic illegal;
   } ctrl_t;

   ctrl_t       dec_ctrl;
   ctrl_t       ctrl_q;
   logic [31:0] dec_imm;
   logic        use_rs1;
   logic        use_rs2;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        hazard;
   logic        adv;

   logic [4:0]  dec_rd;
   assign dec_rd = in_instr[11:7];
   assign rs1    = in_instr[19:15];
   assign rs2    = in_instr[24:20];

   // Opcode decode: controls, source usage and immediate selection
   always_comb begin
      dec_ctrl = '0;
      dec_imm  = '0;
      use_rs1  = 1'b0;
      use_rs2  = 1'b0;
      case (in_instr[6:0])
         OPC_LUI: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.lui       = 1'b1;
            dec_imm            = {in_instr[31:12], 12'b0};
         end
         OPC_AUIPC: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.auipc     = 1'b1;
            dec_imm            = {in_instr[31:12], 12'b0};
         end
         OPC_JAL: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.jal       = 1'b1;
            dec_imm            = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                  in_instr[20], in_instr[30:21], 1'b0};
         end
         OPC_JALR: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.jalr      = 1'b1;
            dec_ctrl.alu_imm   = 1'b1;
            use_rs1            = 1'b1;
            dec_imm            = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_BRANCH: begin
            dec_ctrl.branch = 1'b1;
            use_rs1         = 1'b1;
            use_rs2         = 1'b1;
            dec_imm         = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
         end
         OPC_LOAD: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.mem_read  = 1'b1;
            dec_ctrl.alu_imm   = 1'b1;
            use_rs1            = 1'b1;
            dec_imm            = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_STORE: begin
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_imm   = 1'b1;
            use_rs1            = 1'b1;
            use_rs2            = 1'b1;
            dec_imm            = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         OPC_OPIMM: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_imm   = 1'b1;
            use_rs1            = 1'b1;
            dec_imm            = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         OPC_OP: begin
            dec_ctrl.reg_write = 1'b1;
            use_rs1            = 1'b1;
            use_rs2            = 1'b1;
         end
         default: dec_ctrl.illegal = 1'b1;
      endcase
      if (dec_rd == 5'd0) dec_ctrl.reg_write = 1'b0;
   end

   // Operand read with write-back bypass; x0 is hard-wired to zero
   always_comb begin
      op1 = rd1;
      op2 = rd2;
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1)) op1 = wb_data;
      if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2)) op2 = wb_data;
      if (rs1 == 5'd0) op1 = '0;
      if (rs2 == 5'd0) op2 = '0;
   end

   // Load in ID/EX whose destination feeds a used source of the incoming instruction
   assign hazard = in_valid && out_valid && ctrl_q.mem_read && (out_rd != 5'd0) &&
                   ((use_rs1 && (out_rd == rs1)) || (use_rs2 && (out_rd == rs2)));
   assign adv      = !out_valid || out_ready;
   assign in_ready = !rst && adv && !hazard && !flush;

   // ID/EX pipeline register
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         ctrl_q       <= '0;
         out_pc       <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_imm      <= '0;
         out_rd       <= '0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_funct3   <= '0;
         out_funct7b5 <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         ctrl_q    <= '0;
      end else if (adv) begin
         if (in_valid && !hazard) begin
            out_valid    <= 1'b1;
            ctrl_q       <= dec_ctrl;
            out_pc       <= in_pc;
            out_rs1_val  <= op1;
            out_rs2_val  <= op2;
            out_imm      <= dec_imm;
            out_rd       <= dec_rd;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_funct3   <= in_instr[14:12];
            out_funct7b5 <= in_instr[30];
         end else begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
         end
      end
   end

   assign out_reg_write = ctrl_q.reg_write;
   assign out_mem_read  = ctrl_q.mem_read;
   assign out_mem_write = ctrl_q.mem_write;
   assign out_branch    = ctrl_q.branch;
   assign out_jal       = ctrl_q.jal;
   assign out_jalr      = ctrl_q.jalr;
   assign out_alu_imm   = ctrl_q.alu_imm;
   assign out_lui       = ctrl_q.lui;
   assign out_auipc     = ctrl_q.auipc;
   assign out_illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction sequence, a reference model of
// the stage checked every cycle, and literal expectations for key vectors.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [4:0]  rs1, rs2;
   logic [31:0] rd1, rd2;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;
   logic        out_funct7b5;
   logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal;
   logic        out_jalr, out_alu_imm, out_lui, out_auipc, out_illegal;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
      .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct3(out_funct3),
      .out_funct7b5(out_funct7b5), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_branch(out_branch), .out_jal(out_jal), .out_jalr(out_jalr),
      .out_alu_imm(out_alu_imm), .out_lui(out_lui), .out_auipc(out_auipc),
      .out_illegal(out_illegal)
   );

   // Register file: reads are combinational and see the old value during a write
   logic [31:0] regs [32];
   assign rd1 = regs[rs1];
   assign rd2 = regs[rs2];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode; ctrl order: rw mr mw br jal jalr aimm lui auipc ill
   typedef struct packed {
      logic [9:0]  ctrl;
      logic [31:0] imm;
      logic        u1;
      logic        u2;
   } dec_t;

   function automatic dec_t ref_dec(input logic [31:0] i);
      dec_t d;
      logic [31:0] s;
      s = $signed(i) >>> 20;
      d = '0;
      case (i[6:0])
         7'h37: begin d.ctrl = 10'b1000000100; d.imm = i & 32'hFFFF_F000; end
         7'h17: begin d.ctrl = 10'b1000000010; d.imm = i & 32'hFFFF_F000; end
         7'h6F: begin d.ctrl = 10'b1000100000;
                      d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0}; end
         7'h67: begin d.ctrl = 10'b1000011000; d.imm = s; d.u1 = 1'b1; end
         7'h63: begin d.ctrl = 10'b0001000000; d.u1 = 1'b1; d.u2 = 1'b1;
                      d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0}; end
         7'h03: begin d.ctrl = 10'b1100001000; d.imm = s; d.u1 = 1'b1; end
         7'h23: begin d.ctrl = 10'b0010001000; d.u1 = 1'b1; d.u2 = 1'b1;
                      d.imm = (s & ~32'h1F) | 32'(i[11:7]); end
         7'h13: begin d.ctrl = 10'b1000001000; d.imm = s; d.u1 = 1'b1; end
         7'h33: begin d.ctrl = 10'b1000000000; d.u1 = 1'b1; d.u2 = 1'b1; end
         default: d.ctrl = 10'b0000000001;
      endcase
      if (i[11:7] == 5'd0) d.ctrl[9] = 1'b0;
      return d;
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_we && wb_rd == r) return wb_data;
      return regs[r];
   endfunction

   // Model state: what the ID/EX register must hold
   logic        m_valid;
   logic [9:0]  m_ctrl;
   logic [31:0] m_pc, m_v1, m_v2, m_imm;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic [2:0]  m_f3;
   logic        m_f7;

   function automatic logic m_hazard();
      dec_t d;
      d = ref_dec(in_instr);
      return in_valid && m_valid && m_ctrl[8] && (m_rd != 0) &&
             ((d.u1 && m_rd == in_instr[19:15]) || (d.u2 && m_rd == in_instr[24:20]));
   endfunction

   function automatic logic m_ready();
      return !rst && (!m_valid || out_ready) && !m_hazard() && !flush;
   endfunction

   always @(posedge clk) begin
      dec_t d;
      d = ref_dec(in_instr);
      if (rst) begin
         m_valid = 0; m_ctrl = 0; m_pc = 0; m_v1 = 0; m_v2 = 0; m_imm = 0;
         m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_f3 = 0; m_f7 = 0;
      end else if (flush) begin
         m_valid = 0; m_ctrl = 0;
      end else if (!m_valid || out_ready) begin
         if (in_valid && !m_hazard()) begin
            m_valid = 1; m_ctrl = d.ctrl; m_pc = in_pc; m_imm = d.imm;
            m_v1 = ref_operand(in_instr[19:15]); m_v2 = ref_operand(in_instr[24:20]);
            m_rd = in_instr[11:7]; m_rs1 = in_instr[19:15]; m_rs2 = in_instr[24:20];
            m_f3 = in_instr[14:12]; m_f7 = in_instr[30];
         end else begin
            m_valid = 0; m_ctrl = 0;
         end
      end
      if (wb_we && wb_rd != 0) regs[wb_rd] = wb_data;
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("rs1_addr", 32'(rs1), 32'(in_instr[19:15]));
      chk("rs2_addr", 32'(rs2), 32'(in_instr[24:20]));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal,
                       out_jalr, out_alu_imm, out_lui, out_auipc, out_illegal}), 32'(m_ctrl));
      if (m_valid) begin
         chk("pc", out_pc, m_pc);
         chk("rs1_val", out_rs1_val, m_v1);
         chk("rs2_val", out_rs2_val, m_v2);
         chk("imm", out_imm, m_imm);
         chk("rd", 32'(out_rd), 32'(m_rd));
         chk("rs1_fld", 32'(out_rs1), 32'(m_rs1));
         chk("rs2_fld", 32'(out_rs2), 32'(m_rs2));
         chk("funct3", 32'(out_funct3), 32'(m_f3));
         chk("funct7b5", 32'(out_funct7b5), 32'(m_f7));
      end
   end

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic we,
                        input logic [4:0] wrd, input logic [31:0] wd);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      wb_we = we; wb_rd = wrd; wb_data = wd;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] ADDI  = 32'hFFF0_0293; // addi x5,x0,-1
   localparam logic [31:0] SW    = 32'h0020_A423; // sw x2,8(x1)
   localparam logic [31:0] ADD3  = 32'h0031_8233; // add x4,x3,x3
   localparam logic [31:0] ADD0  = 32'h0000_0233; // add x4,x0,x0
   localparam logic [31:0] LW    = 32'h0000_A303; // lw x6,0(x1)
   localparam logic [31:0] ADD76 = 32'h0023_03B3; // add x7,x6,x2
   localparam logic [31:0] LUI6  = 32'h1234_5337; // lui x6,0x12345
   localparam logic [31:0] JAL   = 32'h0100_00EF; // jal x1,16
   localparam logic [31:0] ILL   = 32'h0000_007F;
   localparam logic [31:0] BEQ   = 32'hFE20_8EE3; // beq x1,x2,-4

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h100 + 32'(i);
      regs[0] = 32'h5555_5555;
      regs[3] = 32'h11;
      rst = 1'b1;
      drive(1, ADDI, 32'h80, 1, 0, 0, 0, 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      tick();
      chk("rst_in_ready2", 32'(in_ready), 0);
      tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_rd", 32'(out_rd), 0);
      rst = 1'b0;

      drive(1, ADDI, 32'h100, 1, 0, 0, 0, 0);
      chk("addi_ready", 32'(in_ready), 1);
      tick();
      chk("addi_imm", out_imm, 32'hFFFF_FFFF);
      chk("addi_rd", 32'(out_rd), 5);
      chk("addi_aimm", 32'(out_alu_imm), 1);
      chk("addi_rw", 32'(out_reg_write), 1);
      chk("addi_x0", out_rs1_val, 0);

      drive(1, SW, 32'h104, 1, 0, 0, 0, 0);
      tick();
      chk("sw_imm", out_imm, 32'd8);
      chk("sw_mw", 32'(out_mem_write), 1);
      chk("sw_rw", 32'(out_reg_write), 0);
      chk("sw_rs2v", out_rs2_val, 32'h102);

      drive(1, ADD3, 32'h108, 1, 0, 1, 5'd3, 32'hDEAD);
      tick();
      chk("byp_rs1", out_rs1_val, 32'hDEAD);
      chk("byp_rs2", out_rs2_val, 32'hDEAD);

      drive(1, ADD0, 32'h10C, 1, 0, 1, 5'd0, 32'hBEEF);
      tick();
      chk("x0_rs1", out_rs1_val, 0);
      chk("x0_rs2", out_rs2_val, 0);

      drive(1, LW, 32'h110, 1, 0, 0, 0, 0);
      tick();
      chk("lw_mr", 32'(out_mem_read), 1);
      drive(1, ADD76, 32'h114, 1, 0, 0, 0, 0);
      chk("lu_stall", 32'(in_ready), 0);
      tick();
      chk("lu_bubble", 32'(out_valid), 0);
      drive(1, ADD76, 32'h114, 1, 0, 1, 5'd6, 32'h1234);
      chk("lu_go", 32'(in_ready), 1);
      tick();
      chk("lu_valid", 32'(out_valid), 1);
      chk("lu_rd", 32'(out_rd), 7);
      chk("lu_byp", out_rs1_val, 32'h1234);
      chk("lu_rs2v", out_rs2_val, 32'h102);

      drive(1, LW, 32'h118, 1, 0, 0, 0, 0);
      tick();
      drive(1, LUI6, 32'h11C, 1, 0, 0, 0, 0);
      chk("lui_nostall", 32'(in_ready), 1);
      tick();
      chk("lui_flag", 32'(out_lui), 1);
      chk("lui_imm", out_imm, 32'h1234_5000);

      drive(1, ADDI, 32'h200, 1, 0, 0, 0, 0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, JAL, 32'h204, 0, 0, 0, 0, 0);
         chk("bp_ready", 32'(in_ready), 0);
         tick();
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_pc", out_pc, 32'h200);
         chk("bp_imm", out_imm, 32'hFFFF_FFFF);
      end
      drive(1, JAL, 32'h204, 0, 1, 0, 0, 0);
      chk("fl_ready", 32'(in_ready), 0);
      tick();
      chk("fl_valid", 32'(out_valid), 0);
      drive(1, JAL, 32'h204, 1, 0, 0, 0, 0);
      chk("jal_ready", 32'(in_ready), 1);
      tick();
      chk("jal_flag", 32'(out_jal), 1);
      chk("jal_imm", out_imm, 32'd16);
      chk("jal_pc", out_pc, 32'h204);

      drive(1, ILL, 32'h300, 1, 0, 0, 0, 0);
      tick();
      chk("ill_valid", 32'(out_valid), 1);
      chk("ill_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal,
                           out_jalr, out_illegal}), 32'h1);

      drive(1, BEQ, 32'h304, 1, 0, 0, 0, 0);
      tick();
      chk("beq_imm", out_imm, 32'hFFFF_FFFC);
      chk("beq_br", 32'(out_branch), 1);

      drive(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
      tick();
      tick();
      chk("idle_valid", 32'(out_valid), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
